// File: rtl/bus_pkg.sv
// Shared bus definitions for the memory arbiter and the processor subsystem.
// Holds arbiter state encodings, default bus widths and the boot vector.
package bus_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 8;
    localparam int BURST_CNT_W = 4;

    // The 6502 fetches its start address from here; proc uses the same constant.
    localparam logic [15:0] RESET_VECTOR = 16'hFFFC;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CPU       = 2'd1,
        ST_DMA       = 2'd2,
        ST_FORCE_CPU = 2'd3
    } arb_state_e;

    function automatic logic rd_issue(input logic gnt, input logic we);
        return gnt & ~we;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU port, the DMA port and the memory side of the arbiter.
// The arbiter uses the slave view; requesters and memory use the master view.
interface mem_arbiter_if import bus_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_rdy;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_lock;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_we;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_addr, cpu_we, cpu_wdata,
        output cpu_rdy, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_lock, dma_addr, dma_we, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_addr, cpu_we, cpu_wdata,
        input  cpu_rdy, cpu_rvalid, cpu_rdata,
        output dma_req, dma_lock, dma_addr, dma_we, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/arb_burst_ctr.sv
// Counts consecutive unlocked DMA grants made while the CPU is waiting and
// flags the grant that must be followed by a forced CPU slot.
module arb_burst_ctr import bus_pkg::*; #(
    parameter int DMA_MAX_BURST = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic dma_gnt_i,
    input  logic cpu_req_i,
    input  logic dma_lock_i,
    output logic at_limit_o
);

    localparam logic [BURST_CNT_W-1:0] LIMIT = BURST_CNT_W'(DMA_MAX_BURST - 1);

    logic [BURST_CNT_W-1:0] burst_cnt_q;
    logic [BURST_CNT_W-1:0] burst_cnt_d;
    logic                   counting;

    assign counting   = dma_gnt_i & cpu_req_i & ~dma_lock_i;
    assign at_limit_o = (burst_cnt_q == LIMIT);

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (!dma_gnt_i || !cpu_req_i) begin
            burst_cnt_d = '0;
        end else if (counting) begin
            // Reaching the limit hands the bus to FORCE_CPU, so the count never
            // needs to sit above LIMIT: clearing there is the saturation point.
            burst_cnt_d = at_limit_o ? '0 : burst_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port system memory between the 6502 core and the DMA engine.
// DMA has fixed priority, bounded by a burst limit that forces a CPU slot.
module mem_arbiter import bus_pkg::*; #(
    parameter int DMA_MAX_BURST = 4,
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              cpu_gnt;
    logic              dma_gnt;
    logic              at_limit;
    logic              force_hit;
    logic              cpu_rvalid_q;
    logic              dma_rvalid_q;
    logic [ADDR_W-1:0] mux_addr;
    logic              mux_we;
    logic [DATA_W-1:0] mux_wdata;

    // Gating with reset_n keeps unknown requests from leaking out during reset.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (reset_n) begin
            if (bus.cpu_req && (!bus.dma_req || state_q == ST_FORCE_CPU)) begin
                cpu_gnt = 1'b1;
            end else if (bus.dma_req) begin
                dma_gnt = 1'b1;
            end
        end
    end

    arb_burst_ctr #(
        .DMA_MAX_BURST (DMA_MAX_BURST)
    ) u_burst_ctr (
        .clk        (clk),
        .reset_n    (reset_n),
        .dma_gnt_i  (dma_gnt),
        .cpu_req_i  (bus.cpu_req),
        .dma_lock_i (bus.dma_lock),
        .at_limit_o (at_limit)
    );

    assign force_hit = dma_gnt & bus.cpu_req & ~bus.dma_lock & at_limit;

    always_comb begin
        state_d = ST_IDLE;
        if (cpu_gnt) begin
            state_d = ST_CPU;
        end else if (dma_gnt) begin
            state_d = force_hit ? ST_FORCE_CPU : ST_DMA;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_rvalid_q <= rd_issue(cpu_gnt, bus.cpu_we);
            dma_rvalid_q <= rd_issue(dma_gnt, bus.dma_we);
        end
    end

    always_comb begin
        mux_addr  = '0;
        mux_we    = 1'b0;
        mux_wdata = '0;
        if (cpu_gnt) begin
            mux_addr  = bus.cpu_addr;
            mux_we    = bus.cpu_we;
            mux_wdata = bus.cpu_wdata;
        end else if (dma_gnt) begin
            mux_addr  = bus.dma_addr;
            mux_we    = bus.dma_we;
            mux_wdata = bus.dma_wdata;
        end
    end

    assign bus.cpu_rdy    = cpu_gnt;
    assign bus.dma_gnt    = dma_gnt;
    assign bus.mem_en     = cpu_gnt | dma_gnt;
    assign bus.mem_addr   = mux_addr;
    assign bus.mem_we     = mux_we;
    assign bus.mem_wdata  = mux_wdata;

    // Read data is shared; each consumer qualifies it with its own rvalid.
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dma_rvalid = dma_rvalid_q;
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.dma_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a rule-level reference model
// (burst counting, one-shot forced CPU slot, one-cycle read return from a shadow memory).
module tb_mem_arbiter;
    import bus_pkg::*;

    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    mem_arbiter #(
        .DMA_MAX_BURST (MAXB),
        .ADDR_W        (16),
        .DATA_W        (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Synchronous memory stand-in, one-cycle read latency.
    logic [7:0] ram     [0:65535];
    logic [7:0] ref_mem [0:65535];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model state
    int         streak;
    bit         force_pend;
    bit         exp_cpu_rv, exp_dma_rv;
    logic [7:0] exp_cpu_rd, exp_dma_rd;
    bit         m_cpu_g, m_dma_g;
    logic       obs_cpu_rdy, obs_dma_gnt, obs_mem_we;

    task automatic model_reset();
        streak     = 0;
        force_pend = 0;
        exp_cpu_rv = 0;
        exp_dma_rv = 0;
        m_cpu_g    = 0;
        m_dma_g    = 0;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic run_cycle();
        bit          cg, dg;
        logic [15:0] ea;
        logic        ew;
        logic [7:0]  ed;
        #1;
        check("cpu_rvalid", bus.cpu_rvalid, exp_cpu_rv);
        check("dma_rvalid", bus.dma_rvalid, exp_dma_rv);
        if (exp_cpu_rv) check("cpu_rdata", bus.cpu_rdata, exp_cpu_rd);
        if (exp_dma_rv) check("dma_rdata", bus.dma_rdata, exp_dma_rd);

        cg = bus.cpu_req && (force_pend || !bus.dma_req);
        dg = bus.dma_req && !cg;
        ea = cg ? bus.cpu_addr  : (dg ? bus.dma_addr  : 16'h0);
        ew = cg ? bus.cpu_we    : (dg ? bus.dma_we    : 1'b0);
        ed = cg ? bus.cpu_wdata : (dg ? bus.dma_wdata : 8'h0);

        obs_cpu_rdy = bus.cpu_rdy;
        obs_dma_gnt = bus.dma_gnt;
        obs_mem_we  = bus.mem_we;
        check("cpu_rdy",   bus.cpu_rdy,   cg);
        check("dma_gnt",   bus.dma_gnt,   dg);
        check("mem_en",    bus.mem_en,    cg | dg);
        check("mem_addr",  bus.mem_addr,  ea);
        check("mem_we",    bus.mem_we,    ew);
        check("mem_wdata", bus.mem_wdata, ed);

        exp_cpu_rv = cg && !bus.cpu_we;
        exp_dma_rv = dg && !bus.dma_we;
        if (exp_cpu_rv) exp_cpu_rd = ref_mem[ea];
        if (exp_dma_rv) exp_dma_rd = ref_mem[ea];
        if ((cg || dg) && ew) ref_mem[ea] = ed;

        // After MAXB unlocked DMA wins against a waiting CPU, the CPU gets the next slot once.
        force_pend = 0;
        if (dg && bus.cpu_req && !bus.dma_lock) begin
            streak++;
            if (streak == MAXB) begin
                force_pend = 1;
                streak     = 0;
            end
        end else if (!(dg && bus.cpu_req && bus.dma_lock)) begin
            streak = 0;
        end
        m_cpu_g = cg;
        m_dma_g = dg;
        @(negedge clk);
    endtask

    task automatic set_cpu(input logic req, input logic [15:0] a, input logic we, input logic [7:0] d);
        bus.cpu_req = req; bus.cpu_addr = a; bus.cpu_we = we; bus.cpu_wdata = d;
    endtask

    task automatic set_dma(input logic req, input logic lock, input logic [15:0] a, input logic we, input logic [7:0] d);
        bus.dma_req = req; bus.dma_lock = lock; bus.dma_addr = a; bus.dma_we = we; bus.dma_wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cpu_cnt;
        int          dma_cnt;
        int          wait_n;
        logic [14:0] pat;

        for (int i = 0; i < 65536; i++) ram[i] = 8'(i * 7 + 3);
        ram[16'hFFFC] = 8'h00;
        ram[16'hFFFD] = 8'hC0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = ram[i];

        // Reset held with both requesters active
        reset_n = 1'b0;
        set_cpu(1'b1, RESET_VECTOR, 1'b0, 8'h00);
        set_dma(1'b1, 1'b0, 16'h0100, 1'b0, 8'h00);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_cpu_rdy",    bus.cpu_rdy,    1'b0);
        check("rst_dma_gnt",    bus.dma_gnt,    1'b0);
        check("rst_mem_en",     bus.mem_en,     1'b0);
        check("rst_mem_addr",   bus.mem_addr,   16'h0);
        check("rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
        check("rst_dma_rvalid", bus.dma_rvalid, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        run_cycle();
        check("first_grant_dma", obs_dma_gnt, 1'b1);

        // CPU alone fetching the boot vector
        set_dma(1'b0, 1'b0, 16'h0, 1'b0, 8'h0);
        set_cpu(1'b1, RESET_VECTOR, 1'b0, 8'h00);
        run_cycle();
        check("boot_lo", bus.cpu_rdata, 8'h00);
        set_cpu(1'b1, RESET_VECTOR + 16'h1, 1'b0, 8'h00);
        run_cycle();
        check("boot_hi", bus.cpu_rdata, 8'hC0);
        set_cpu(1'b0, 16'h0, 1'b0, 8'h00);
        run_cycle();

        // Contention without lock: D,D,D,D,C repeating
        set_cpu(1'b1, 16'h0300, 1'b0, 8'h00);
        set_dma(1'b1, 1'b0, 16'h0100, 1'b0, 8'h00);
        cpu_cnt = 0;
        pat = '0;
        for (int i = 0; i < 15; i++) begin
            run_cycle();
            pat[i] = obs_cpu_rdy;
            if (obs_cpu_rdy) cpu_cnt++;
        end
        check("contention_pattern", 32'(pat), 32'h4210);
        check("contention_cpu_slots", 32'(cpu_cnt), 32'd3);

        // Locked burst, then release
        bus.dma_lock = 1'b1;
        dma_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            if (obs_dma_gnt) dma_cnt++;
        end
        check("locked_dma_grants", 32'(dma_cnt), 32'd10);
        bus.dma_lock = 1'b0;
        wait_n = 0;
        do begin
            run_cycle();
            wait_n++;
        end while (!obs_cpu_rdy && wait_n < 8);
        check("unlock_cpu_latency_ok", 32'(wait_n >= 1 && wait_n <= MAXB + 1), 32'd1);

        // DMA write followed by CPU read of the same byte
        set_cpu(1'b0, 16'h0, 1'b0, 8'h00);
        set_dma(1'b1, 1'b0, 16'h0200, 1'b1, 8'h5A);
        run_cycle();
        check("wr_cycle_we", obs_mem_we, 1'b1);
        set_dma(1'b0, 1'b0, 16'h0, 1'b0, 8'h00);
        set_cpu(1'b1, 16'h0200, 1'b0, 8'h00);
        run_cycle();
        check("rd_cycle_we", obs_mem_we, 1'b0);
        check("wr_rd_data", bus.cpu_rdata, 8'h5A);
        check("wr_rd_dma_rvalid", bus.dma_rvalid, 1'b0);
        set_cpu(1'b0, 16'h0, 1'b0, 8'h00);
        run_cycle();

        // Reset during a read grant: rvalid must never appear
        set_cpu(1'b1, 16'h0200, 1'b0, 8'h00);
        #1;
        check("midrst_grant", bus.cpu_rdy, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_rdy_drop", bus.cpu_rdy, 1'b0);
        check("midrst_mem_en", bus.mem_en, 1'b0);
        @(posedge clk);
        #1;
        check("midrst_no_rvalid", bus.cpu_rvalid, 1'b0);
        @(negedge clk);
        set_cpu(1'b0, 16'h0, 1'b0, 8'h00);
        model_reset();
        reset_n = 1'b1;
        run_cycle();

        // Reset arriving while rvalid is already high clears it without a clock
        set_cpu(1'b1, 16'h0200, 1'b0, 8'h00);
        run_cycle();
        set_cpu(1'b0, 16'h0, 1'b0, 8'h00);
        check("async_pre_rvalid", bus.cpu_rvalid, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async_rvalid_clear", bus.cpu_rvalid, 1'b0);
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        run_cycle();

        // Randomised traffic; requesters hold their request until granted
        set_dma(1'b0, 1'b0, 16'h0, 1'b0, 8'h00);
        for (int i = 0; i < 600; i++) begin
            if (!bus.cpu_req || m_cpu_g)
                set_cpu($urandom_range(0, 3) != 0, 16'h0300 | 16'($urandom_range(0, 15)),
                        $urandom_range(0, 2) == 0, 8'($urandom));
            if (!bus.dma_req || m_dma_g)
                set_dma($urandom_range(0, 3) != 0, bus.dma_lock, 16'h0300 | 16'($urandom_range(0, 15)),
                        $urandom_range(0, 2) == 0, 8'($urandom));
            if ($urandom_range(0, 7) == 0) bus.dma_lock = ~bus.dma_lock;
            run_cycle();
        end

        set_cpu(1'b0, 16'h0, 1'b0, 8'h00);
        set_dma(1'b0, 1'b0, 16'h0, 1'b0, 8'h00);
        run_cycle();
        run_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
